// File: rtl/kyber_pkg.sv
// Kyber-wide constants and the coefficient type.
package kyber_pkg;

   localparam int unsigned KYBER_Q   = 3329;
   localparam int unsigned KYBER_N   = 256;
   localparam int unsigned COEFF_WID = 12;

   typedef logic [COEFF_WID-1:0] coeff_t;

endpackage : kyber_pkg

// File: rtl/mod_add_q.sv
// mod_add_q: combinational single-lane modular adder.
//   Computes (i_a + i_b) mod Q for operands already in [0, Q-1] using one
//   conditional subtraction on a DATA_WID+1 bit sum.
// Ports:
//   i_a, i_b  operands in [0, Q-1]
//   o_r       reduced sum in [0, Q-1]
module mod_add_q
   import kyber_pkg::*;
#(
   parameter int unsigned DATA_WID = COEFF_WID,
   parameter int unsigned Q        = KYBER_Q
) (
   input  logic [DATA_WID-1:0] i_a,
   input  logic [DATA_WID-1:0] i_b,
   output logic [DATA_WID-1:0] o_r
);

   localparam logic [DATA_WID:0] QX = (DATA_WID+1)'(Q);

   logic [DATA_WID:0] w_s;

   assign w_s = {1'b0, i_a} + {1'b0, i_b};
   assign o_r = (w_s >= QX) ? DATA_WID'(w_s - QX) : DATA_WID'(w_s);

endmodule : mod_add_q

// File: rtl/poly_mod_adder.sv
// poly_mod_adder: streaming two-stage, multi-lane modular coefficient adder.
//   Stage 1 reduces a + b, stage 2 optionally adds c and reduces again.
//   A beat counter tags the final beat of each N_COEFF-coefficient polynomial.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   use_c                three-operand add for the accepted beat
//   in_valid / in_ready  input handshake (in_ready = !out_valid || out_ready)
//   in_a, in_b, in_c     packed operands, lane k at [k*DATA_WID +: DATA_WID]
//   out_valid/out_ready  output handshake
//   out_sum, out_last    registered reduced sums and last-beat flag
//   range_err            one-cycle pulse after accepting an operand >= Q
// Optional feature: define POLY_ADD_RANGE_CHECK_EN to build the operand
// range check; otherwise range_err is tied low.
module poly_mod_adder
   import kyber_pkg::*;
#(
   parameter int unsigned DATA_WID = COEFF_WID,
   parameter int unsigned LANES    = 4,
   parameter int unsigned N_COEFF  = KYBER_N,
   parameter int unsigned Q        = KYBER_Q
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      use_c,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_WID-1:0] in_a,
   input  logic [LANES*DATA_WID-1:0] in_b,
   input  logic [LANES*DATA_WID-1:0] in_c,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DATA_WID-1:0] out_sum,
   output logic                      out_last,
   output logic                      range_err
);

   localparam int unsigned BEATS = N_COEFF / LANES;
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEATS - 1);

   logic w_advance;
   logic w_accept;

   // Stage 1 registers
   logic                      r1_valid;
   logic [LANES*DATA_WID-1:0] r1_sum;
   logic [LANES*DATA_WID-1:0] r1_c;
   logic                      r1_use_c;
   logic                      r1_last;

   // Stage 2 registers drive the outputs directly
   logic                      r2_valid;
   logic [LANES*DATA_WID-1:0] r2_sum;
   logic                      r2_last;

   logic [CNT_W-1:0]          r_cnt;

   logic [LANES*DATA_WID-1:0] w_s1;
   logic [LANES*DATA_WID-1:0] w_s2;

   // No skid buffer: accept only when the output register will be free.
   assign w_advance = !r2_valid || out_ready;
   assign in_ready  = w_advance;
   assign w_accept  = in_valid && w_advance;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      mod_add_q #(
         .DATA_WID (DATA_WID),
         .Q        (Q)
      ) u_add_ab (
         .i_a (in_a[k*DATA_WID +: DATA_WID]),
         .i_b (in_b[k*DATA_WID +: DATA_WID]),
         .o_r (w_s1[k*DATA_WID +: DATA_WID])
      );

      mod_add_q #(
         .DATA_WID (DATA_WID),
         .Q        (Q)
      ) u_add_c (
         .i_a (r1_sum[k*DATA_WID +: DATA_WID]),
         .i_b (r1_c[k*DATA_WID +: DATA_WID]),
         .o_r (w_s2[k*DATA_WID +: DATA_WID])
      );
   end

   // Beat counter: advances only on accepted beats, wraps after the last one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1_valid <= 1'b0;
         r1_sum   <= '0;
         r1_c     <= '0;
         r1_use_c <= 1'b0;
         r1_last  <= 1'b0;
      end else if (w_advance) begin
         r1_valid <= w_accept;
         if (w_accept) begin
            r1_sum   <= w_s1;
            r1_c     <= in_c;
            r1_use_c <= use_c;
            r1_last  <= (r_cnt == CNT_MAX);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r2_valid <= 1'b0;
         r2_sum   <= '0;
         r2_last  <= 1'b0;
      end else if (w_advance) begin
         r2_valid <= r1_valid;
         if (r1_valid) begin
            r2_sum  <= r1_use_c ? w_s2 : r1_sum;
            r2_last <= r1_last;
         end
      end
   end

   assign out_valid = r2_valid;
   assign out_sum   = r2_sum;
   assign out_last  = r2_last;

`ifdef POLY_ADD_RANGE_CHECK_EN
   localparam logic [DATA_WID-1:0] QW = DATA_WID'(Q);

   logic w_bad;
   logic r_range_err;

   always_comb begin
      w_bad = 1'b0;
      for (int k = 0; k < int'(LANES); k++) begin
         if (in_a[k*DATA_WID +: DATA_WID] >= QW ||
             in_b[k*DATA_WID +: DATA_WID] >= QW ||
             (use_c && in_c[k*DATA_WID +: DATA_WID] >= QW)) begin
            w_bad = 1'b1;
         end
      end
   end

   // Sampled every cycle so the flag self-clears after one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_range_err <= 1'b0;
      end else begin
         r_range_err <= w_accept && w_bad;
      end
   end

   assign range_err = r_range_err;
`else
   assign range_err = 1'b0;
`endif

endmodule : poly_mod_adder

// File: tb/tb_poly_mod_adder.sv
// Testbench for poly_mod_adder: directed beats, a queue-based reference model
// computing (a + b [+ c]) mod Q with plain integer arithmetic, and a single
// compare process that checks outputs every cycle.
module tb_poly_mod_adder;
   import kyber_pkg::*;

   localparam int L     = 4;
   localparam int DW    = COEFF_WID;
   localparam int QQ    = KYBER_Q;
   localparam int BEATS = KYBER_N / L;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            use_c = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [L*DW-1:0] in_a = '0;
   logic [L*DW-1:0] in_b = '0;
   logic [L*DW-1:0] in_c = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [L*DW-1:0] out_sum;
   logic            out_last;
   logic            range_err;

   poly_mod_adder dut (
      .clk       (clk),
      .rst       (rst),
      .use_c     (use_c),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_last  (out_last),
      .range_err (range_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [L*DW-1:0] sum;
      logic            last;
      bit              dc;
      int              stamp;
   } exp_t;

   exp_t q[$];
   int   idx = 0;
   int   cyc = 0;
   int   last_stall = -100;
   bit   head_seen = 0;
   bit   prev_stall = 0;
   logic [L*DW-1:0] prev_sum = '0;
   logic prev_last = 1'b0;
   bit   exp_rerr = 0;
   int   nout = 0;
   int   nlast = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [L*DW-1:0] model_sum(input logic [L*DW-1:0] a, b, c,
                                                  input logic uc);
      logic [L*DW-1:0] r;
      r = '0;
      for (int k = 0; k < L; k++) begin
         int s;
         s = int'(a[k*DW +: DW]) + int'(b[k*DW +: DW]) + (uc ? int'(c[k*DW +: DW]) : 0);
         r[k*DW +: DW] = DW'(s % QQ);
      end
      return r;
   endfunction

   function automatic bit any_bad(input logic [L*DW-1:0] a, b, c, input logic uc);
      bit bad;
      bad = 0;
      for (int k = 0; k < L; k++) begin
         if (int'(a[k*DW +: DW]) >= QQ || int'(b[k*DW +: DW]) >= QQ ||
             (uc && int'(c[k*DW +: DW]) >= QQ)) bad = 1;
      end
      return bad;
   endfunction

   function automatic logic [L*DW-1:0] pack4(input int l0, l1, l2, l3);
      logic [L*DW-1:0] r;
      r = {DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
      return r;
   endfunction

   // Compare process: samples mid-cycle, after inputs settle, before the next edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (rst) begin
            q.delete();
            idx = 0;
            head_seen = 0;
            prev_stall = 0;
            exp_rerr = 0;
            nout = 0;
            nlast = 0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_sum", 64'(out_sum), 64'd0);
            chk("rst_out_last", 64'(out_last), 64'd0);
            chk("rst_range_err", 64'(range_err), 64'd0);
         end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (prev_stall) begin
               chk("stall_valid_hold", 64'(out_valid), 64'd1);
               chk("stall_sum_hold", 64'(out_sum), 64'(prev_sum));
               chk("stall_last_hold", 64'(out_last), 64'(prev_last));
            end
            if (out_valid) begin
               if (q.size() == 0) begin
                  chk("unexpected_beat", 64'(out_valid), 64'd0);
               end else begin
                  if (!q[0].dc) chk("out_sum", 64'(out_sum), 64'(q[0].sum));
                  chk("out_last", 64'(out_last), 64'(q[0].last));
                  if (!head_seen) begin
                     head_seen = 1;
                     if (last_stall < q[0].stamp)
                        chk("latency", 64'(cyc - q[0].stamp), 64'd2);
                  end
                  if (out_ready) begin
                     nout++;
                     if (out_last) nlast++;
                     void'(q.pop_front());
                     head_seen = 0;
                  end
               end
            end
`ifdef POLY_ADD_RANGE_CHECK_EN
            chk("range_err", 64'(range_err), 64'(exp_rerr));
`else
            chk("range_err_off", 64'(range_err), 64'd0);
`endif
            exp_rerr = 0;
            prev_stall = out_valid && !out_ready;
            prev_sum = out_sum;
            prev_last = out_last;
            if (!out_ready) last_stall = cyc;
            if (in_valid && in_ready) begin
               exp_t e;
               e.sum   = model_sum(in_a, in_b, in_c, use_c);
               e.last  = (idx == BEATS - 1);
               e.dc    = any_bad(in_a, in_b, in_c, use_c);
               e.stamp = cyc;
               exp_rerr = e.dc;
               q.push_back(e);
               idx = (idx + 1) % BEATS;
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge following acceptance.
   task automatic send(input logic [L*DW-1:0] a, b, c, input logic uc);
      bit ok;
      ok = 0;
      in_a = a;
      in_b = b;
      in_c = c;
      use_c = uc;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         #2;
         ok = in_ready;
         @(negedge clk);
      end
      if (!ok) chk("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic send_rand(input logic uc);
      logic [L*DW-1:0] a, b, c;
      for (int k = 0; k < L; k++) begin
         a[k*DW +: DW] = DW'($urandom_range(0, QQ - 1));
         b[k*DW +: DW] = DW'($urandom_range(0, QQ - 1));
         c[k*DW +: DW] = DW'($urandom_range(0, QQ - 1));
      end
      send(a, b, c, uc);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("reset_async_valid", 64'(out_valid), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #3;
      chk("ready_after_reset", 64'(in_ready), 64'd1);
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain_done", 64'(q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #3;
      chk("ready_after_reset", 64'(in_ready), 64'd1);
      @(negedge clk);

      // Two-operand: 3328+1 wraps to 0, 100+200 = 300.
      send(pack4(3328, 100, 5, 0), pack4(1, 200, 7, 0), pack4(9, 9, 9, 9), 1'b0);
      @(negedge clk);
      #3;
      chk("lit_valid_2cyc", 64'(out_valid), 64'd1);
      chk("lit_lane0_wrap", 64'(out_sum[DW-1:0]), 64'd0);
      chk("lit_lane1_300", 64'(out_sum[2*DW-1:DW]), 64'd300);
      chk("lit_lane2_12", 64'(out_sum[3*DW-1:2*DW]), 64'd12);
      @(negedge clk);

      // Three-operand: 3*3328 mod Q = 3326; 0+0+3328 = 3328.
      send(pack4(3328, 3328, 3328, 3328), pack4(3328, 3328, 3328, 3328),
           pack4(3328, 3328, 3328, 3328), 1'b1);
      send(pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), pack4(3328, 3328, 3328, 3328), 1'b1);
      #3;
      chk("lit_3op_max", 64'(out_sum), 64'(pack4(3326, 3326, 3326, 3326)));
      @(negedge clk);
      #3;
      chk("lit_3op_c_only", 64'(out_sum), 64'(pack4(3328, 3328, 3328, 3328)));
      @(negedge clk);
      drain();

      // Full polynomial plus four beats of the next, back to back.
      do_reset();
      for (int i = 0; i < BEATS + 4; i++) send_rand(1'(i % 2));
      drain();
      chk("lit_poly_beats", 64'(nout), 64'(BEATS + 4));
      chk("lit_poly_lasts", 64'(nlast), 64'd1);

      // Backpressure: out_ready low for 5 cycles mid-stream.
      fork
         for (int i = 0; i < 20; i++) send_rand(1'b1);
         begin
            repeat (6) @(negedge clk);
            out_ready = 1'b0;
            #3;
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            repeat (5) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset mid-polynomial after 10 beats, then a full fresh polynomial.
      do_reset();
      for (int i = 0; i < 10; i++) send_rand(1'b0);
      do_reset();
      for (int i = 0; i < BEATS; i++) send_rand(1'b0);
      drain();
      chk("lit_fresh_beats", 64'(nout), 64'(BEATS));
      chk("lit_fresh_lasts", 64'(nlast), 64'd1);

`ifdef POLY_ADD_RANGE_CHECK_EN
      send(pack4(1, 2, 3329, 4), pack4(1, 2, 3, 4), pack4(0, 0, 0, 0), 1'b0);
      #3;
      chk("lit_range_pulse", 64'(range_err), 64'd1);
      @(negedge clk);
      #3;
      chk("lit_range_clear", 64'(range_err), 64'd0);
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_poly_mod_adder
